// File: rtl/uart_tx_frame_pkg.sv
// rtl/uart_tx_frame_pkg.sv - state encodings and shared constants for the UART frame serialiser
package uart_tx_frame_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ALIGN  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  localparam logic LINE_IDLE = 1'b1;

  function automatic bit stop_bits_legal(input int n);
    return (n == 1) || (n == 2);
  endfunction

  function automatic bit width_legal(input int n);
    return (n >= 5) && (n <= 9);
  endfunction

endpackage

// File: rtl/uart_tx_frame_piso.sv
// rtl/uart_tx_frame_piso.sv - load/shift register with emitted-bit counter for the frame serialiser
module uart_tx_frame_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic             bit_out,
  output logic             last
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;

  // cnt counts bits already emitted; last means the whole word is out
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= load_data;
      cnt   <= '0;
    end else if (shift) begin
      shreg <= {1'b0, shreg[WIDTH-1:1]};
      cnt   <= cnt + CW'(1);
    end
  end

  assign bit_out = shreg[0];
  assign last    = (cnt == CW'(WIDTH));

endmodule

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - UART frame serialiser (start, data LSB first, optional parity via UART_TX_PARITY_EN, stop)
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic             baud_tick,
  input  logic             p_in,
  output logic             load_bit,
  output logic [WIDTH-1:0] par_data,
  output logic             tx_out,
  output logic             tx_busy,
  output logic             tx_done
);

  if (!stop_bits_legal(STOP_BITS)) begin : g_bad_stop
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end
  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("uart_tx_frame: WIDTH must be 5..9");
  end

  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  logic [2:0] state, state_nxt;
  logic       accept;
  logic       piso_shift, piso_bit, piso_last;
  logic       tx_out_nxt, done_nxt;
  logic       stop_cnt, stop_clr, stop_inc;
  logic       load_q;

  assign accept   = tx_valid && (state == S_IDLE);
  assign tx_ready = (state == S_IDLE);
  assign tx_busy  = (state != S_IDLE);

  uart_tx_frame_piso #(.WIDTH(WIDTH)) u_piso (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .load_data (tx_data),
    .shift     (piso_shift),
    .bit_out   (piso_bit),
    .last      (piso_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx_out   <= LINE_IDLE;
      tx_done  <= 1'b0;
      load_q   <= 1'b0;
      par_data <= '0;
      stop_cnt <= 1'b0;
    end else begin
      state    <= state_nxt;
      tx_out   <= tx_out_nxt;
      tx_done  <= done_nxt;
      load_q   <= accept;
      if (accept)        par_data <= tx_data;
      if (stop_clr)      stop_cnt <= 1'b0;
      else if (stop_inc) stop_cnt <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept)    state_nxt = S_ALIGN;
      S_ALIGN:  if (baud_tick) state_nxt = S_START;
      S_START:  if (baud_tick) state_nxt = S_DATA;
`ifdef UART_TX_PARITY_EN
      S_DATA:   if (baud_tick && piso_last) state_nxt = S_PARITY;
      S_PARITY: if (baud_tick) state_nxt = S_STOP;
`else
      S_DATA:   if (baud_tick && piso_last) state_nxt = S_STOP;
`endif
      S_STOP:   if (baud_tick && (stop_cnt == STOP_LAST)) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // tx_out_nxt is the line level for the tick period that starts at the next edge
  always_comb begin
    tx_out_nxt = tx_out;
    done_nxt   = 1'b0;
    piso_shift = 1'b0;
    stop_clr   = 1'b0;
    stop_inc   = 1'b0;
    case (state)
      S_IDLE:  tx_out_nxt = LINE_IDLE;
      S_ALIGN: if (baud_tick) tx_out_nxt = 1'b0;
      S_START: if (baud_tick) begin
        tx_out_nxt = piso_bit;
        piso_shift = 1'b1;
      end
      S_DATA: if (baud_tick) begin
        if (!piso_last) begin
          tx_out_nxt = piso_bit;
          piso_shift = 1'b1;
        end else begin
`ifdef UART_TX_PARITY_EN
          tx_out_nxt = p_in;
`else
          tx_out_nxt = LINE_IDLE;
          stop_clr   = 1'b1;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (baud_tick) begin
        tx_out_nxt = LINE_IDLE;
        stop_clr   = 1'b1;
      end
`endif
      S_STOP: if (baud_tick) begin
        if (stop_cnt == STOP_LAST) done_nxt = 1'b1;
        else                       stop_inc = 1'b1;
      end
      default: tx_out_nxt = LINE_IDLE;
    endcase
  end

`ifdef UART_TX_PARITY_EN
  assign load_bit = load_q;
`else
  logic unused_inputs;
  assign unused_inputs = p_in ^ load_q;
  assign load_bit      = 1'b0;
`endif

endmodule
